// File: rtl/alu_n_bit_seq.sv
// Registered N-bit ALU (AND/OR/ADD/SUB/SLT/NOR) with START/BUSY/DONE handshake.
// Define ALU_N_BIT_SEQ_MUL_EN to build in the iterative unsigned shift-add multiplier.
module alu_n_bit_seq #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             AINV,
  input  logic             BNEG,
  input  logic [1:0]       Opr,
  input  logic             MUL,
  output logic [WIDTH-1:0] RESULT,
  output logic [WIDTH-1:0] RESULT_HI,
  output logic             OVERFLOW,
  output logic             ZERO,
  output logic             COUT,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [1:0] {IDLE_S = 2'b00, MULT_S = 2'b01, DONE_S = 2'b10} state_t;

  state_t           state_r;
  logic [WIDTH-1:0] result_r;
  logic [WIDTH-1:0] result_hi_r;
  logic             overflow_r;
  logic             zero_r;
  logic             cout_r;
  logic             busy_r;
  logic             done_r;

  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_s;
  logic [WIDTH:0]   sum_s;
  logic             add_ovf_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_ovf_s;
  logic             alu_cout_s;
  logic             alu_zero_s;

  // Single-cycle ALU datapath on the live operands
  always_comb begin
    a_s        = AINV ? ~A : A;
    b_s        = BNEG ? ~B : B;
    sum_s      = {1'b0, a_s} + {1'b0, b_s} + {{WIDTH{1'b0}}, BNEG};
    add_ovf_s  = (a_s[WIDTH-1] == b_s[WIDTH-1]) && (sum_s[WIDTH-1] != a_s[WIDTH-1]);
    alu_res_s  = {WIDTH{1'b0}};
    alu_ovf_s  = 1'b0;
    alu_cout_s = 1'b0;
    case (Opr)
      2'b00: alu_res_s = a_s & b_s;
      2'b01: alu_res_s = a_s | b_s;
      2'b10: begin
        alu_res_s  = sum_s[WIDTH-1:0];
        alu_ovf_s  = add_ovf_s;
        alu_cout_s = sum_s[WIDTH];
      end
      2'b11: begin
        // Signed less-than: sign of the difference corrected by overflow
        alu_res_s  = {{(WIDTH-1){1'b0}}, sum_s[WIDTH-1] ^ add_ovf_s};
        alu_ovf_s  = add_ovf_s;
        alu_cout_s = sum_s[WIDTH];
      end
      default: alu_res_s = {WIDTH{1'b0}};
    endcase
    alu_zero_s = (alu_res_s == {WIDTH{1'b0}});
  end

`ifdef ALU_N_BIT_SEQ_MUL_EN
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0]   mcand_r;
  logic [2*WIDTH:0]   acc_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH:0]     step_add_s;
  logic [2*WIDTH:0]   acc_nxt_s;
  logic               cnt_last_s;

  // One shift-add iteration: conditional add into {carry, hi}, then shift right
  always_comb begin
    if (acc_r[0]) begin
      step_add_s = acc_r[2*WIDTH:WIDTH] + {1'b0, mcand_r};
    end else begin
      step_add_s = acc_r[2*WIDTH:WIDTH];
    end
    acc_nxt_s  = {1'b0, step_add_s, acc_r[WIDTH-1:1]};
    cnt_last_s = (cnt_r == CNT_W'(WIDTH - 1));
  end
`else
  logic unused_mul_s;
  assign unused_mul_s = MUL;
`endif

  // Control FSM with registered results; outputs only move on completion or Reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r     <= IDLE_S;
      result_r    <= {WIDTH{1'b0}};
      result_hi_r <= {WIDTH{1'b0}};
      overflow_r  <= 1'b0;
      zero_r      <= 1'b0;
      cout_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
`ifdef ALU_N_BIT_SEQ_MUL_EN
      mcand_r     <= {WIDTH{1'b0}};
      acc_r       <= {(2*WIDTH+1){1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
`endif
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE_S, DONE_S: begin
          if (START) begin
`ifdef ALU_N_BIT_SEQ_MUL_EN
            if (MUL) begin
              mcand_r <= A;
              acc_r   <= {{(WIDTH+1){1'b0}}, B};
              cnt_r   <= {CNT_W{1'b0}};
              busy_r  <= 1'b1;
              state_r <= MULT_S;
            end else begin
`endif
              result_r    <= alu_res_s;
              result_hi_r <= {WIDTH{1'b0}};
              overflow_r  <= alu_ovf_s;
              zero_r      <= alu_zero_s;
              cout_r      <= alu_cout_s;
              done_r      <= 1'b1;
              state_r     <= DONE_S;
`ifdef ALU_N_BIT_SEQ_MUL_EN
            end
`endif
          end else begin
            state_r <= IDLE_S;
          end
        end
`ifdef ALU_N_BIT_SEQ_MUL_EN
        MULT_S: begin
          acc_r <= acc_nxt_s;
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_last_s) begin
            result_r    <= acc_nxt_s[WIDTH-1:0];
            result_hi_r <= acc_nxt_s[2*WIDTH-1:WIDTH];
            overflow_r  <= (acc_nxt_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
            zero_r      <= (acc_nxt_s[2*WIDTH-1:0] == {(2*WIDTH){1'b0}});
            cout_r      <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
            state_r     <= DONE_S;
          end else begin
            state_r <= MULT_S;
          end
        end
`endif
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE_S;
        end
      endcase
    end
  end

  assign RESULT    = result_r;
  assign RESULT_HI = result_hi_r;
  assign OVERFLOW  = overflow_r;
  assign ZERO      = zero_r;
  assign COUT      = cout_r;
  assign BUSY      = busy_r;
  assign DONE      = done_r;

endmodule

// File: tb/tb_alu_n_bit_seq.sv
// Directed self-checking bench for alu_n_bit_seq at WIDTH=4.
// Multiply scenarios run when ALU_N_BIT_SEQ_MUL_EN is defined; otherwise MUL is checked as ignored.
module tb_alu_n_bit_seq;
  localparam int W = 4;

  logic         Clk;
  logic         Reset;
  logic         START;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         AINV;
  logic         BNEG;
  logic [1:0]   Opr;
  logic         MUL;
  logic [W-1:0] RESULT;
  logic [W-1:0] RESULT_HI;
  logic         OVERFLOW;
  logic         ZERO;
  logic         COUT;
  logic         BUSY;
  logic         DONE;

  int n_checks = 0;
  int n_errors = 0;

  alu_n_bit_seq #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .START(START), .A(A), .B(B),
    .AINV(AINV), .BNEG(BNEG), .Opr(Opr), .MUL(MUL),
    .RESULT(RESULT), .RESULT_HI(RESULT_HI), .OVERFLOW(OVERFLOW),
    .ZERO(ZERO), .COUT(COUT), .BUSY(BUSY), .DONE(DONE)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_ops(input logic [W-1:0] a, input logic [W-1:0] b, input logic ainv,
                         input logic bneg, input logic [1:0] opr, input logic mul);
    A = a; B = b; AINV = ainv; BNEG = bneg; Opr = opr; MUL = mul;
  endtask

  // One single-cycle op: DONE and results in the next cycle, then back to idle with outputs held
  task automatic run_alu(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ainv, input logic bneg, input logic [1:0] opr, input logic mul,
                         input logic [W-1:0] exp_res, input logic exp_ovf, input logic exp_zero,
                         input logic exp_cout);
    set_ops(a, b, ainv, bneg, opr, mul);
    START = 1'b1;
    step();
    START = 1'b0;
    check_val({tag, "_done"}, DONE, 1);
    check_val({tag, "_res"}, RESULT, exp_res);
    check_val({tag, "_hi"}, RESULT_HI, 0);
    check_val({tag, "_flags_ozc"}, {OVERFLOW, ZERO, COUT}, {exp_ovf, exp_zero, exp_cout});
    check_val({tag, "_busy"}, BUSY, 0);
    step();
    check_val({tag, "_done_drop"}, DONE, 0);
    check_val({tag, "_hold"}, RESULT, exp_res);
  endtask

`ifdef ALU_N_BIT_SEQ_MUL_EN
  task automatic run_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic poke, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                         input logic exp_ovf, input logic exp_zero);
    int lat;
    lat = 0;
    set_ops(a, b, 1'b0, 1'b0, 2'b00, 1'b1);
    START = 1'b1;
    step();
    START = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      if (DONE) begin
        lat = n;
        break;
      end
      check_val({tag, "_busy"}, BUSY, 1);
      if (poke && n == 2) begin
        set_ops(4'hF, 4'hF, 1'b0, 1'b0, 2'b10, 1'b1);
        START = 1'b1;
      end else begin
        START = 1'b0;
      end
      step();
    end
    START = 1'b0;
    check_val({tag, "_latency"}, lat, W + 1);
    check_val({tag, "_hi"}, RESULT_HI, exp_hi);
    check_val({tag, "_lo"}, RESULT, exp_lo);
    check_val({tag, "_flags_ozcb"}, {OVERFLOW, ZERO, COUT, BUSY}, {exp_ovf, exp_zero, 1'b0, 1'b0});
    step();
    check_val({tag, "_done_drop"}, DONE, 0);
  endtask
`endif

  initial begin
    Reset = 1'b1;
    START = 1'b1;
    set_ops(4'd7, 4'd11, 1'b0, 1'b0, 2'b10, 1'b0);
    step();
    check_val("rst_no_done1", DONE, 0);
    step();
    check_val("rst_no_done2", DONE, 0);
    check_val("rst_outs", {RESULT_HI, RESULT, OVERFLOW, ZERO, COUT, BUSY, DONE}, 0);
    Reset = 1'b0;
    START = 1'b0;
    step();
    check_val("idle_no_done", DONE, 0);

    run_alu("add_7_11", 4'd7,    4'd11,   1'b0, 1'b0, 2'b10, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1);
    run_alu("add_4_5",  4'd4,    4'd5,    1'b0, 1'b0, 2'b10, 1'b0, 4'b1001, 1'b1, 1'b0, 1'b0);
    run_alu("sub",      4'b1011, 4'b0111, 1'b0, 1'b1, 2'b10, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b1);
    run_alu("slt_lt",   4'b1011, 4'b0111, 1'b0, 1'b1, 2'b11, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b1);
    run_alu("slt_eq",   4'b0101, 4'b0101, 1'b0, 1'b1, 2'b11, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
    run_alu("nor",      4'b0011, 4'b0101, 1'b1, 1'b1, 2'b00, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0);
    run_alu("or",       4'b0011, 4'b0101, 1'b0, 1'b0, 2'b01, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b0);

    // Back-to-back: START held for three ADDs
    set_ops(4'd1, 4'd2, 1'b0, 1'b0, 2'b10, 1'b0);
    START = 1'b1;
    step();
    check_val("b2b1_done", DONE, 1);
    check_val("b2b1_res", RESULT, 4'd3);
    set_ops(4'd2, 4'd5, 1'b0, 1'b0, 2'b10, 1'b0);
    step();
    check_val("b2b2_done", DONE, 1);
    check_val("b2b2_res", RESULT, 4'd7);
    set_ops(4'd6, 4'd7, 1'b0, 1'b0, 2'b10, 1'b0);
    step();
    START = 1'b0;
    check_val("b2b3_done", DONE, 1);
    check_val("b2b3_res", RESULT, 4'd13);
    check_val("b2b3_flags_ozc", {OVERFLOW, ZERO, COUT}, 3'b100);
    step();
    check_val("b2b_done_drop", DONE, 0);

`ifdef ALU_N_BIT_SEQ_MUL_EN
    run_mul("mul_13_11", 4'd13, 4'd11, 1'b0, 4'b1000, 4'b1111, 1'b1, 1'b0);
    run_mul("mul_3_5",   4'd3,  4'd5,  1'b0, 4'b0000, 4'b1111, 1'b0, 1'b0);
    run_mul("mul_0_9",   4'd0,  4'd9,  1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
    run_mul("mul_poke",  4'd3,  4'd5,  1'b1, 4'b0000, 4'b1111, 1'b0, 1'b0);

    // Reset during the second multiply cycle
    set_ops(4'd13, 4'd11, 1'b0, 1'b0, 2'b00, 1'b1);
    START = 1'b1;
    step();
    START = 1'b0;
    step();
    check_val("rstmul_busy", BUSY, 1);
    Reset = 1'b1;
    step();
`else
    // MUL is ignored: executes the selected ALU op in one cycle
    run_alu("mul_ign", 4'd2, 4'd3, 1'b0, 1'b0, 2'b10, 1'b1, 4'b0101, 1'b0, 1'b0, 1'b0);

    set_ops(4'd7, 4'd11, 1'b0, 1'b0, 2'b10, 1'b0);
    START = 1'b1;
    step();
    Reset = 1'b1;
    step();
    START = 1'b0;
`endif
    Reset = 1'b0;
    check_val("rstmid_outs", {RESULT_HI, RESULT, OVERFLOW, ZERO, COUT, BUSY, DONE}, 0);
    step();
    check_val("rstmid_idle1", {BUSY, DONE}, 0);
    step();
    check_val("rstmid_idle2", {BUSY, DONE}, 0);
    run_alu("add_after_rst", 4'd2, 4'd3, 1'b0, 1'b0, 2'b10, 1'b0, 4'b0101, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
